// File: rtl/hpdcache_id_alloc_ctrl.sv
// Transaction-ID allocator around a preloaded free-ID FIFO.
// Grants are zero-latency pops from the FIFO head. In-flight IDs are tracked in a
// bitmap plus a counter. Releases are checked against the bitmap and then pushed
// back through a single-entry write stage. A drain FSM stops new grants and
// reports idle once every ID has returned to the FIFO.
module hpdcache_id_alloc_ctrl #(
    parameter int unsigned NUM_IDS = 8,
    parameter int unsigned ID_W    = $clog2(NUM_IDS),
    parameter int unsigned CNT_W   = $clog2(NUM_IDS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    output logic [ID_W-1:0]    alloc_id_o,
    input  logic               rel_valid_i,
    output logic               rel_ready_o,
    input  logic [ID_W-1:0]    rel_id_i,
    output logic               fifo_r_o,
    input  logic               fifo_rok_i,
    input  logic [ID_W-1:0]    fifo_rdata_i,
    output logic               fifo_w_o,
    input  logic               fifo_wok_i,
    output logic [ID_W-1:0]    fifo_wdata_o,
    input  logic               drain_i,
    output logic               idle_o,
    output logic [NUM_IDS-1:0] inflight_o,
    output logic [CNT_W-1:0]   inflight_cnt_o,
    output logic               err_dbl_free_o
);

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

    state_e             state_q;
    logic [NUM_IDS-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wstage_vld_q, wstage_vld_d;
    logic [ID_W-1:0]    wstage_id_q, wstage_id_d;
    logic               err_q;
    logic               grant, rel_acc, rel_ok;

    assign alloc_ready_o = fifo_rok_i & (state_q == RUN);
    assign alloc_id_o    = fifo_rdata_i;
    assign grant         = alloc_valid_i & alloc_ready_o;
    assign fifo_r_o      = grant;

    // The stage can take a new ID in the same cycle its current entry retires.
    assign rel_ready_o   = ~wstage_vld_q | fifo_wok_i;
    assign rel_acc       = rel_valid_i & rel_ready_o;
    // The bitmap is sampled before this cycle's grant. A release that races its
    // own grant therefore sees a 0 bit and is dropped as a double free.
    assign rel_ok        = rel_acc & inflight_q[rel_id_i];

    assign fifo_w_o       = wstage_vld_q;
    assign fifo_wdata_o   = wstage_id_q;
    assign inflight_o     = inflight_q;
    assign inflight_cnt_o = cnt_q;
    assign err_dbl_free_o = err_q;
    assign idle_o         = (state_q == IDLE);

    // Next-state for the bitmap, the counter and the write stage
    always_comb begin
        inflight_d = inflight_q;
        if (grant)  inflight_d[alloc_id_o] = 1'b1;
        if (rel_ok) inflight_d[rel_id_i]   = 1'b0;

        cnt_d = cnt_q;
        if (grant && !rel_ok)      cnt_d = cnt_q + CNT_W'(1);
        else if (!grant && rel_ok) cnt_d = cnt_q - CNT_W'(1);

        wstage_vld_d = wstage_vld_q;
        wstage_id_d  = wstage_id_q;
        if (rel_ok) begin
            wstage_vld_d = 1'b1;
            wstage_id_d  = rel_id_i;
        end else if (wstage_vld_q && fifo_wok_i) begin
            wstage_vld_d = 1'b0;
        end
    end

    // Datapath registers; the error pulse flags any accepted release of a non-allocated ID
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q   <= '0;
            cnt_q        <= '0;
            wstage_vld_q <= 1'b0;
            wstage_id_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            cnt_q        <= cnt_d;
            wstage_vld_q <= wstage_vld_d;
            wstage_id_q  <= wstage_id_d;
            err_q        <= rel_acc & ~inflight_q[rel_id_i];
        end
    end

    // Drain FSM: idle requires every ID returned and the write stage flushed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (drain_i) state_q <= DRAIN;
                DRAIN:   if (!drain_i) state_q <= RUN;
                         else if (cnt_q == '0 && !wstage_vld_q) state_q <= IDLE;
                IDLE:    if (!drain_i) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    // The counter is a cached popcount of the bitmap and can never exceed the ID count
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(cnt_q) <= int'(NUM_IDS));
    a_cnt_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(cnt_q) == $countones(inflight_q));

endmodule

// File: tb/tb_hpdcache_id_alloc_ctrl.sv
// Directed bench for hpdcache_id_alloc_ctrl with NUM_IDS=4 and a small behavioural
// free-ID FIFO that is preloaded 0..3 on reset.
module tb_hpdcache_id_alloc_ctrl;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       alloc_valid = 1'b0, alloc_ready;
    logic [1:0] alloc_id;
    logic       rel_valid = 1'b0, rel_ready;
    logic [1:0] rel_id = '0;
    logic       fifo_r, fifo_rok, fifo_w, fifo_wok;
    logic [1:0] fifo_rdata, fifo_wdata;
    logic       drain = 1'b0, idle, err;
    logic [3:0] inflight;
    logic [2:0] cnt;
    logic       wok_en = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hpdcache_id_alloc_ctrl #(.NUM_IDS(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
        .rel_valid_i(rel_valid), .rel_ready_o(rel_ready), .rel_id_i(rel_id),
        .fifo_r_o(fifo_r), .fifo_rok_i(fifo_rok), .fifo_rdata_i(fifo_rdata),
        .fifo_w_o(fifo_w), .fifo_wok_i(fifo_wok), .fifo_wdata_o(fifo_wdata),
        .drain_i(drain), .idle_o(idle), .inflight_o(inflight),
        .inflight_cnt_o(cnt), .err_dbl_free_o(err)
    );

    // Behavioural free-ID FIFO
    logic [1:0] mem [N];
    int         head, fcnt;
    assign fifo_rok   = (fcnt > 0);
    assign fifo_rdata = mem[head];
    assign fifo_wok   = (fcnt < N) && wok_en;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            head <= 0;
            fcnt <= N;
            for (int i = 0; i < N; i++) mem[i] <= 2'(i);
        end else begin
            if (fifo_w && fifo_wok) mem[(head + fcnt) % N] <= fifo_wdata;
            head <= fifo_r ? (head + 1) % N : head;
            fcnt <= fcnt - ((fifo_r && fifo_rok) ? 1 : 0) + ((fifo_w && fifo_wok) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (inflight !== 4'b0000) begin errors++; $display("FAIL rst_inflight got=%b exp=0000", inflight); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
        checks++; if (fifo_w !== 1'b0 || err !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL rst_outs got w=%b err=%b idle=%b exp=0,0,0", fifo_w, err, idle); end
        tick();
        rst_ni = 1'b1;
        smp();
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 2'd0) begin errors++; $display("FAIL rst_ready got rdy=%b id=%0d exp 1,0", alloc_ready, alloc_id); end
        tick();
    endtask

    task automatic test_alloc();
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (i < 4) begin
                checks++; if (alloc_ready !== 1'b1 || alloc_id !== 2'(i) || fifo_r !== 1'b1) begin errors++; $display("FAIL alloc_grant%0d got rdy=%b id=%0d r=%b exp 1,%0d,1", i, alloc_ready, alloc_id, fifo_r, i); end
            end else begin
                checks++; if (alloc_ready !== 1'b0 || fifo_r !== 1'b0) begin errors++; $display("FAIL alloc_empty got rdy=%b r=%b exp 0,0", alloc_ready, fifo_r); end
            end
            tick();
        end
        alloc_valid = 1'b0;
        smp();
        checks++; if (cnt !== 3'd4 || inflight !== 4'b1111) begin errors++; $display("FAIL alloc_full got cnt=%0d inf=%b exp 4,1111", cnt, inflight); end
        tick();
    endtask

    task automatic test_release();
        rel_valid = 1'b1; rel_id = 2'd2;
        smp();
        checks++; if (rel_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", rel_ready); end
        tick();
        rel_valid = 1'b0;
        smp();
        checks++; if (inflight !== 4'b1011 || cnt !== 3'd3) begin errors++; $display("FAIL rel_state got inf=%b cnt=%0d exp 1011,3", inflight, cnt); end
        checks++; if (fifo_w !== 1'b1 || fifo_wdata !== 2'd2) begin errors++; $display("FAIL rel_push got w=%b d=%0d exp 1,2", fifo_w, fifo_wdata); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL rel_early_realloc got rdy=%b exp 0", alloc_ready); end
        tick();
        // ID 2 is back in the FIFO; release it again while it is not in flight
        rel_valid = 1'b1; rel_id = 2'd2;
        smp();
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 2'd2 || rel_ready !== 1'b1) begin errors++; $display("FAIL realloc got rdy=%b id=%0d rrdy=%b exp 1,2,1", alloc_ready, alloc_id, rel_ready); end
        tick();
        rel_valid = 1'b0;
        smp();
        checks++; if (err !== 1'b1 || fifo_w !== 1'b0 || cnt !== 3'd3 || inflight !== 4'b1011) begin errors++; $display("FAIL dbl_free got err=%b w=%b cnt=%0d inf=%b exp 1,0,3,1011", err, fifo_w, cnt, inflight); end
        tick();
        smp();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dbl_free_pulse got err=%b exp 0", err); end
        tick();
    endtask

    task automatic test_backpressure();
        wok_en = 1'b0;
        rel_valid = 1'b1; rel_id = 2'd0;
        smp();
        checks++; if (rel_ready !== 1'b1) begin errors++; $display("FAIL bp_first got rrdy=%b exp 1", rel_ready); end
        tick();
        rel_id = 2'd1;
        smp();
        checks++; if (rel_ready !== 1'b0 || fifo_w !== 1'b1 || fifo_wdata !== 2'd0) begin errors++; $display("FAIL bp_stall got rrdy=%b w=%b d=%0d exp 0,1,0", rel_ready, fifo_w, fifo_wdata); end
        tick();
        smp();
        checks++; if (rel_ready !== 1'b0) begin errors++; $display("FAIL bp_stall2 got rrdy=%b exp 0", rel_ready); end
        tick();
        wok_en = 1'b1;
        smp();
        checks++; if (rel_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got rrdy=%b exp 1", rel_ready); end
        tick();
        rel_valid = 1'b0;
        smp();
        checks++; if (fifo_w !== 1'b1 || fifo_wdata !== 2'd1) begin errors++; $display("FAIL bp_second got w=%b d=%0d exp 1,1", fifo_w, fifo_wdata); end
        tick();
        smp();
        checks++; if (fifo_w !== 1'b0 || cnt !== 3'd1 || inflight !== 4'b1000) begin errors++; $display("FAIL bp_done got w=%b cnt=%0d inf=%b exp 0,1,1000", fifo_w, cnt, inflight); end
        tick();
    endtask

    task automatic test_drain();
        // FIFO holds 2,0,1; take 2 so IDs 2 and 3 are in flight
        alloc_valid = 1'b1;
        smp();
        checks++; if (alloc_id !== 2'd2) begin errors++; $display("FAIL drain_pre got id=%0d exp 2", alloc_id); end
        tick();
        alloc_valid = 1'b0; drain = 1'b1;
        smp();
        checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL drain_cnt got cnt=%0d exp 2", cnt); end
        tick();
        smp();
        checks++; if (alloc_ready !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL drain_block got rdy=%b idle=%b exp 0,0", alloc_ready, idle); end
        tick();
        rel_valid = 1'b1; rel_id = 2'd3;
        tick();
        rel_id = 2'd2;
        smp();
        checks++; if (rel_ready !== 1'b1) begin errors++; $display("FAIL drain_rel got rrdy=%b exp 1", rel_ready); end
        tick();
        rel_valid = 1'b0;
        smp();
        checks++; if (fifo_w !== 1'b1 || fifo_wdata !== 2'd2 || cnt !== 3'd0 || idle !== 1'b0) begin errors++; $display("FAIL drain_last got w=%b d=%0d cnt=%0d idle=%b exp 1,2,0,0", fifo_w, fifo_wdata, cnt, idle); end
        tick();
        smp();
        checks++; if (idle !== 1'b0 || fifo_w !== 1'b0) begin errors++; $display("FAIL drain_wait got idle=%b w=%b exp 0,0", idle, fifo_w); end
        tick();
        smp();
        checks++; if (idle !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL drain_idle got idle=%b rdy=%b exp 1,0", idle, alloc_ready); end
        tick();
        drain = 1'b0;
        tick();
        smp();
        checks++; if (idle !== 1'b0 || alloc_ready !== 1'b1 || alloc_id !== 2'd0) begin errors++; $display("FAIL drain_resume got idle=%b rdy=%b id=%0d exp 0,1,0", idle, alloc_ready, alloc_id); end
        tick();
    endtask

    task automatic test_same_cycle();
        alloc_valid = 1'b1;
        smp();
        checks++; if (alloc_id !== 2'd0) begin errors++; $display("FAIL same_pre got id=%0d exp 0", alloc_id); end
        tick();
        rel_valid = 1'b1; rel_id = 2'd1;
        smp();
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 2'd1 || rel_ready !== 1'b1) begin errors++; $display("FAIL same_req got rdy=%b id=%0d rrdy=%b exp 1,1,1", alloc_ready, alloc_id, rel_ready); end
        tick();
        alloc_valid = 1'b0; rel_valid = 1'b0;
        smp();
        checks++; if (err !== 1'b1 || inflight !== 4'b0011 || cnt !== 3'd2 || fifo_w !== 1'b0) begin errors++; $display("FAIL same_res got err=%b inf=%b cnt=%0d w=%b exp 1,0011,2,0", err, inflight, cnt, fifo_w); end
        tick();
    endtask

    task automatic test_async_reset();
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (inflight !== 4'b0000 || cnt !== 3'd0 || fifo_w !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL arst got inf=%b cnt=%0d w=%b idle=%b exp 0000,0,0,0", inflight, cnt, fifo_w, idle); end
        tick();
        rst_ni = 1'b1;
        drain = 1'b1;
        smp();
        checks++; if (alloc_id !== 2'd0 || idle !== 1'b0) begin errors++; $display("FAIL arst_fifo got id=%0d idle=%b exp 0,0", alloc_id, idle); end
        tick();
        smp();
        checks++; if (idle !== 1'b0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL empty_drain1 got idle=%b rdy=%b exp 0,0", idle, alloc_ready); end
        tick();
        smp();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL empty_drain2 got idle=%b exp 1", idle); end
        tick();
        drain = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_release();
        test_backpressure();
        test_drain();
        test_same_cycle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
